alu_share_arb: RTL and testbench

- Two-requester controller that time-shares the single RV32I ALU, including its alu_ctl decoder, between the hart execute stage (port 0) and an auxiliary unit such as a CSR or debug engine (port 1).
- Arbitrates round-robin and registers the winning operands and control codes onto the ALU inputs.
- Captures the ALU result and returns it to the winning requester over a valid/ready response handshake.

---
 rtl/alu_share_arb.sv | 136 +++++++++++++
 tb/tb_alu_share_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter that time-shares one RV32I ALU between two requesters.
// Optional perf counters are enabled by defining ALU_SHARE_ARB_PERF_EN.
module alu_share_arb #(
  parameter int XLEN      = 32,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_req_valid,
  output logic [1:0]      o_req_ready,
  input  logic [XLEN-1:0] i_req_op1_0,
  input  logic [XLEN-1:0] i_req_op1_1,
  input  logic [XLEN-1:0] i_req_op2_0,
  input  logic [XLEN-1:0] i_req_op2_1,
  input  logic [1:0]      i_req_aluop_0,
  input  logic [1:0]      i_req_aluop_1,
  input  logic [3:0]      i_req_func_0,
  input  logic [3:0]      i_req_func_1,
  output logic [XLEN-1:0] o_alu_op1,
  output logic [XLEN-1:0] o_alu_op2,
  output logic [1:0]      o_alu_aluop,
  output logic [3:0]      o_alu_func,
  input  logic [XLEN-1:0] i_alu_result,
  output logic [1:0]      o_rsp_valid,
  input  logic [1:0]      i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_result,
`ifdef ALU_SHARE_ARB_PERF_EN
  output logic [31:0]     o_grant_cnt0,
  output logic [31:0]     o_grant_cnt1,
  output logic [31:0]     o_conflict_cnt,
`endif
  output logic            o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          r_state, w_next;
  logic            r_grant, r_prio;
  logic [XLEN-1:0] r_op1, r_op2, r_result;
  logic [1:0]      r_aluop;
  logic [3:0]      r_func;
  logic [1:0]      w_ready;
  logic            w_xfer, w_win, w_done;

  // Tie goes to r_prio; a lone requester is served regardless of priority.
  always_comb begin
    w_ready = 2'b00;
    if (r_state == S_IDLE) begin
      if (&i_req_valid) w_ready[r_prio] = 1'b1;
      else              w_ready = i_req_valid;
    end
  end

  assign w_xfer = |(i_req_valid & w_ready);
  assign w_win  = w_ready[1];
  assign w_done = (r_state == S_RESP) && i_rsp_ready[r_grant];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = w_ready;
    o_rsp_valid = 2'b00;
    o_busy      = 1'b0;
    case (r_state)
      S_EXEC:  o_busy = 1'b1;
      S_RESP: begin
        o_busy               = 1'b1;
        o_rsp_valid[r_grant] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_grant  <= PRIO_INIT;
      r_prio   <= PRIO_INIT;
      r_op1    <= '0;
      r_op2    <= '0;
      r_aluop  <= 2'b00;
      r_func   <= 4'b0000;
      r_result <= '0;
    end else begin
      if (w_xfer) begin
        r_grant <= w_win;
        r_op1   <= w_win ? i_req_op1_1   : i_req_op1_0;
        r_op2   <= w_win ? i_req_op2_1   : i_req_op2_0;
        r_aluop <= w_win ? i_req_aluop_1 : i_req_aluop_0;
        r_func  <= w_win ? i_req_func_1  : i_req_func_0;
      end
      if (r_state == S_EXEC) r_result <= i_alu_result;
      // The requester just served loses the next tie.
      if (w_done) r_prio <= ~r_grant;
    end
  end

  assign o_alu_op1    = r_op1;
  assign o_alu_op2    = r_op2;
  assign o_alu_aluop  = r_aluop;
  assign o_alu_func   = r_func;
  assign o_rsp_result = r_result;

`ifdef ALU_SHARE_ARB_PERF_EN
  logic [31:0] r_cnt0, r_cnt1, r_conf;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_conf <= '0;
    end else begin
      if (w_xfer && !w_win && !(&r_cnt0)) r_cnt0 <= r_cnt0 + 32'd1;
      if (w_xfer &&  w_win && !(&r_cnt1)) r_cnt1 <= r_cnt1 + 32'd1;
      if ((r_state == S_IDLE) && (&i_req_valid) && !(&r_conf)) r_conf <= r_conf + 32'd1;
    end
  end

  assign o_grant_cnt0   = r_cnt0;
  assign o_grant_cnt1   = r_cnt1;
  assign o_conflict_cnt = r_conf;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU and a response scoreboard.
// Perf-counter checks are compiled in when ALU_SHARE_ARB_PERF_EN is defined.
module tb_alu_share_arb;
  localparam int XLEN = 32;

  typedef struct {
    int               port;
    logic [XLEN-1:0]  res;
  } sb_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = 2'b00, req_ready, rsp_valid, rsp_ready = 2'b00;
  logic [XLEN-1:0] op1_0 = '0, op1_1 = '0, op2_0 = '0, op2_1 = '0;
  logic [1:0]      aop_0 = '0, aop_1 = '0, alu_aluop;
  logic [3:0]      fn_0 = '0, fn_1 = '0, alu_func;
  logic [XLEN-1:0] alu_op1, alu_op2, alu_res, rsp_result;
  logic            busy;
`ifdef ALU_SHARE_ARB_PERF_EN
  logic [31:0]     g0, g1, conf;
`endif

  int  n_tests = 0;
  int  n_fail  = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  alu_share_arb #(.XLEN(XLEN), .PRIO_INIT(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op1_0(op1_0), .i_req_op1_1(op1_1),
    .i_req_op2_0(op2_0), .i_req_op2_1(op2_1),
    .i_req_aluop_0(aop_0), .i_req_aluop_1(aop_1),
    .i_req_func_0(fn_0), .i_req_func_1(fn_1),
    .o_alu_op1(alu_op1), .o_alu_op2(alu_op2),
    .o_alu_aluop(alu_aluop), .o_alu_func(alu_func),
    .i_alu_result(alu_res),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result),
`ifdef ALU_SHARE_ARB_PERF_EN
    .o_grant_cnt0(g0), .o_grant_cnt1(g1), .o_conflict_cnt(conf),
`endif
    .o_busy(busy)
  );

  // Reference RV32I ALU: alu_op class plus {funct7[5], funct3}.
  function automatic logic [XLEN-1:0] alu_model(logic [1:0] aop, logic [3:0] f,
                                                 logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic [3:0] ff;
    ff = f;
    if (aop == 2'b10) return b;
    if (aop == 2'b01 && f[2:0] != 3'b101) ff = {1'b0, f[2:0]};
    if (aop == 2'b11) ff = 4'b0000;
    case (ff)
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return {31'd0, $signed(a) < $signed(b)};
      4'b0011: return {31'd0, a < b};
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return a + b;
    endcase
  endfunction

  always_comb alu_res = alu_model(alu_aluop, alu_func, alu_op1, alu_op2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic set_port(input int p, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [1:0] aop, input logic [3:0] f);
    if (p == 0) begin op1_0 = a; op2_0 = b; aop_0 = aop; fn_0 = f; end
    else        begin op1_1 = a; op2_1 = b; aop_1 = aop; fn_1 = f; end
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic txn(input logic [1:0] vmask, input int gp, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input logic [1:0] aop, input logic [3:0] f,
                     input logic [XLEN-1:0] exp, input int bp);
    sb_t e;
    logic [1:0] gbit;
    gbit = (gp == 1) ? 2'b10 : 2'b01;
    set_port(gp, a, b, aop, f);
    req_valid = vmask;
    #1 chk("req_ready", req_ready, gbit);
    e.port = gp; e.res = exp;
    sb.push_back(e);
    @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("exec_ready", req_ready, 2'b00);
    chk("alu_func", alu_func, f);
    chk("alu_aluop", alu_aluop, aop);
    chk("alu_op1", alu_op1, a);
    chk("alu_op2", alu_op2, b);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, gbit);
    for (int i = 0; i < bp; i++) begin
      rsp_ready = ~gbit;
      @(negedge clk);
      chk("bp_valid", rsp_valid, gbit);
      chk("bp_result", rsp_result, exp);
      chk("bp_ready", req_ready, 2'b00);
      chk("bp_alu_op1", alu_op1, a);
    end
    rsp_ready = gbit;
    if (sb.size() == 0) chk("sb_underflow", 1, 0);
    else begin
      e = sb.pop_front();
      chk("rsp_port", rsp_valid, (e.port == 1) ? 2'b10 : 2'b01);
      chk("rsp_result", rsp_result, e.res);
    end
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("done_idle", busy, 0);
    chk("done_valid", rsp_valid, 2'b00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_op1", alu_op1, 0);
    chk("rst_op2", alu_op2, 0);
    chk("rst_aluop", alu_aluop, 2'b00);
    chk("rst_func", alu_func, 4'b0000);
    chk("rst_result", rsp_result, 0);
    chk("rst_req_ready", req_ready, 2'b00);
  endtask

  initial begin
    logic [XLEN-1:0] ra, rb;
    logic [3:0]      rf;
    logic [3:0]      funcs [4];
    funcs[0] = 4'b0000; funcs[1] = 4'b1000; funcs[2] = 4'b0100; funcs[3] = 4'b1101;

    do_reset();
    chk_reset_outputs();

    txn(2'b01, 0, 32'd5, 32'd7, 2'b00, 4'b0000, 32'd12, 0);
    req_valid = 2'b00;
    txn(2'b10, 1, 32'd10, 32'd3, 2'b00, 4'b1000, 32'd7, 2);
    txn(2'b10, 1, 32'h8000_0000, 32'd4, 2'b01, 4'b1101, 32'hF800_0000, 3);
    req_valid = 2'b00;

    // Tie with priority back at port 0 after port 1 was last served.
    set_port(1, 32'd10, 32'd3, 2'b00, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) txn(2'b11, 0, 32'd5, 32'd7, 2'b00, 4'b0000, 32'd12, 0);
      else            txn(2'b11, 1, 32'd10, 32'd3, 2'b00, 4'b1000, 32'd7, 0);
    end
    req_valid = 2'b00;

    txn(2'b01, 0, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 2'b00, 4'b0100, 32'hD1A2_B1E0, 5);
    txn(2'b01, 0, 32'h1234_5678, 32'hCAFE_F00D, 2'b10, 4'b0111, 32'hCAFE_F00D, 0);
    req_valid = 2'b00;

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rf = funcs[$urandom_range(0, 3)];
      txn((i % 2 == 0) ? 2'b10 : 2'b01, (i % 2 == 0) ? 1 : 0, ra, rb, 2'b00, rf,
          alu_model(2'b00, rf, ra, rb), i % 3);
      req_valid = 2'b00;
    end

    // Reset while in EXEC: the request is dropped with no response.
    set_port(0, 32'd100, 32'd1, 2'b00, 4'b0000);
    req_valid = 2'b01;
    @(negedge clk);
    chk("mid_exec_busy", busy, 1);
    req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_exec_novalid", rsp_valid, 2'b00);
    end

    // Reset while in RESP.
    set_port(1, 32'd50, 32'd8, 2'b00, 4'b1000);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("mid_resp_valid", rsp_valid, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_resp_novalid", rsp_valid, 2'b00);
    end
    txn(2'b10, 1, 32'd50, 32'd8, 2'b00, 4'b1000, 32'd42, 1);
    req_valid = 2'b00;

`ifdef ALU_SHARE_ARB_PERF_EN
    do_reset();
    chk("perf_rst_g0", g0, 0);
    chk("perf_rst_g1", g1, 0);
    chk("perf_rst_conf", conf, 0);
    set_port(1, 32'd10, 32'd3, 2'b00, 4'b1000);
    txn(2'b11, 0, 32'd5, 32'd7, 2'b00, 4'b0000, 32'd12, 0);
    txn(2'b11, 1, 32'd10, 32'd3, 2'b00, 4'b1000, 32'd7, 0);
    txn(2'b01, 0, 32'd1, 32'd2, 2'b00, 4'b0000, 32'd3, 0);
    txn(2'b01, 0, 32'd9, 32'd4, 2'b00, 4'b1000, 32'd5, 0);
    txn(2'b10, 1, 32'hF0, 32'h0F, 2'b00, 4'b0110, 32'hFF, 0);
    req_valid = 2'b00;
    @(negedge clk);
    chk("perf_g0", g0, 3);
    chk("perf_g1", g1, 2);
    chk("perf_conf", conf, 2);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
